// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART transmitter.
//   uart_state_e    : transmitter FSM state encoding
//   cycles_per_bit(): clk cycles per line bit (integer division)
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt -- bit-period timer for the UART transmitter.
// Ports:
//   clk      : system clock
//   resetn   : asynchronous active-low reset
//   run      : count while high; counter held at zero while low
//   bit_tick : high in the last cycle of each bit period
module uart_baud_cnt #(
  parameter int CYCLES_PER_BIT = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = $clog2(CYCLES_PER_BIT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = run && (cnt_q == CW'(CYCLES_PER_BIT - 1));

  // Cleared on every bit boundary, so it never wraps inside a bit.
  always_comb begin
    cnt_d = '0;
    if (run && !bit_tick) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter: start bit, PAYLOAD_BITS data bits LSB first,
// optional even parity bit, STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data).
// Ports:
//   clk           : system clock, rising edge
//   resetn        : asynchronous active-low reset, aborts any frame
//   uart_tx_valid : request to send uart_tx_data
//   uart_tx_data  : payload, latched on acceptance
//   uart_tx_ready : high only in IDLE
//   uart_tx_busy  : inverse of uart_tx_ready
//   uart_txd      : serial line, idle high, registered
//
// state  | meaning
// IDLE   | line high, ready to accept a byte
// START  | line low for one bit period
// DATA   | shifting payload out LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_BITS bit periods
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int BW             = $clog2(PAYLOAD_BITS) + 1;

  generate
    if (CYCLES_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_HZ/BIT_RATE must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]           bit_cnt_inc;
  logic                    txd_q, txd_d;
  logic                    bit_tick;
  logic                    accept;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  assign uart_tx_ready = (state_q == ST_IDLE);
  assign uart_tx_busy  = ~uart_tx_ready;
  assign uart_txd      = txd_q;
  assign accept        = uart_tx_valid && uart_tx_ready;
  assign bit_cnt_inc   = bit_cnt_q + BW'(1);

  uart_baud_cnt #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .run      (uart_tx_busy),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = uart_tx_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^uart_tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_inc == BW'(PAYLOAD_BITS)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_inc;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // bit_cnt reused to count stop bits
        if (bit_tick) begin
          if (bit_cnt_inc == BW'(STOP_BITS)) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so txd stays registered.
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) parity_q <= 1'b0;
    else         parity_q <= parity_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 10 clk cycles per bit. Two instances: one with one
// stop bit, one with two. Build with UART_TX_PARITY_EN to cover parity.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic [7:0] data = 8'h00;
  logic       txd1, ready1, busy1;
  logic       txd2, ready2, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .resetn(resetn), .uart_tx_valid(valid1), .uart_tx_data(data),
    .uart_tx_ready(ready1), .uart_tx_busy(busy1), .uart_txd(txd1));

  uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .uart_tx_valid(valid2), .uart_tx_data(data),
    .uart_tx_ready(ready2), .uart_tx_busy(busy2), .uart_txd(txd2));

  // frame: bit i is the i-th bit on the line (start, 8 data LSB first, stop)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_line(input logic [9:0] frame, input logic par, input int b);
    if (b <= 8) return frame[b];
    if (PAR_BITS == 1 && b == 9) return par;
    return 1'b1;
  endfunction

  // Called at the negedge that is the first START cycle. Samples every cycle,
  // returns at the negedge of the first cycle after the last stop cycle.
  // mode 1: change data to FF and pulse valid mid-frame
  // mode 2: change data to 00 mid-frame, valid left high
  task automatic check_frame(input string name, input bit sel, input logic [9:0] frame,
                             input logic par, input int stop_bits, input int mode);
    int          total;
    int          low;
    logic [12:0] bad_mask;
    logic        t, r;
    total    = (1 + 8 + PAR_BITS + stop_bits) * CPB;
    low      = 0;
    bad_mask = '0;
    for (int c = 0; c < total; c++) begin
      t = sel ? txd2 : txd1;
      r = sel ? ready2 : ready1;
      if (r === 1'b0) low++;
      if (t !== exp_line(frame, par, c / CPB)) bad_mask[c / CPB] = 1'b1;
      if (mode == 1) begin
        if (c == 3)  data = 8'hFF;
        if (c == 40) valid1 = 1'b1;
        if (c == 41) valid1 = 1'b0;
      end
      if (mode == 2 && c == 3) data = 8'h00;
      @(negedge clk);
    end
    check({name, " bad bit mask"}, 32'(bad_mask), 32'h0);
    check({name, " busy cycles"}, low, total);
    check({name, " ready after stop"}, sel ? ready2 : ready1, 1);
    check({name, " txd after stop"}, sel ? txd2 : txd1, 1);
  endtask

  // Called at a negedge with the DUT idle; returns at the first START negedge.
  task automatic send(input bit sel, input logic [7:0] d);
    check("ready before send", sel ? ready2 : ready1, 1);
    data = d;
    if (sel) valid2 = 1'b1;
    else     valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 10'h346, 1'b0};
    vecs[2] = '{8'h00, 10'h200, 1'b0};
    vecs[3] = '{8'h0F, 10'h21E, 1'b0};
    vecs[4] = '{8'h81, 10'h302, 1'b0};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    vecs[6] = '{8'h03, 10'h206, 1'b0};
    vecs[7] = '{8'hC3, 10'h386, 1'b0};
    vecs[8] = '{8'hFF, 10'h3FE, 1'b0};

    repeat (2) @(negedge clk);
    check("reset txd", txd1, 1);
    check("reset ready", ready1, 1);
    check("reset busy", busy1, 0);
    check("reset txd stop2", txd2, 1);

    // First frame is offered on the same negedge reset is released.
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(1'b0, vecs[i].data);
      check_frame($sformatf("vec%0d_%02h", i, vecs[i].data), 1'b0,
                  vecs[i].frame, vecs[i].par, 1, 0);
    end

    // Input changes and valid pulses while busy are ignored.
    send(1'b0, 8'h0F);
    check("busy during frame", busy1, 1);
    check_frame("hold_0F", 1'b0, 10'h21E, 1'b0, 1, 1);
    @(negedge clk);
    check("dropped valid txd", txd1, 1);
    check("dropped valid ready", ready1, 1);

    // Back-to-back with valid held: one ready cycle, then the next start bit.
    data   = 8'hA3;
    valid1 = 1'b1;
    @(negedge clk);
    check_frame("b2b_A3", 1'b0, 10'h346, 1'b0, 1, 2);
    @(negedge clk);
    valid1 = 1'b0;
    check_frame("b2b_00", 1'b0, 10'h200, 1'b0, 1, 0);

    // Reset in data bit 3 of 0x81 (line low there), then resend.
    send(1'b0, 8'h81);
    repeat (45) @(negedge clk);
    check("pre-reset txd bit3", txd1, 0);
    resetn = 1'b0;
    #1;
    check("abort txd", txd1, 1);
    check("abort ready", ready1, 1);
    check("abort busy", busy1, 0);
    @(negedge clk);
    check("in-reset txd", txd1, 1);
    resetn = 1'b1;
    send(1'b0, 8'h81);
    check_frame("after_reset_81", 1'b0, 10'h302, 1'b0, 1, 0);

    // Two stop bits.
    send(1'b1, 8'hC3);
    check_frame("stop2_C3", 1'b1, 10'h386, 1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
